// File: rtl/nios_dbg_jtag_initiator_if.sv
// Command/response handshake and virtual-JTAG pins of nios_dbg_jtag_initiator.
//   slave  : the initiator itself (accepts commands, drives the vji_* pins)
//   master : the host side (issues commands, consumes responses, returns tdo)
interface nios_dbg_jtag_initiator_if #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [IR_WIDTH-1:0] cmd_ir;
   logic [DR_WIDTH-1:0] cmd_dr;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DR_WIDTH-1:0] rsp_dr;
   logic                vji_tck;
   logic                vji_tdi;
   logic                vji_tdo;
   logic [IR_WIDTH-1:0] vji_ir_in;
   logic                vji_uir;
   logic                vji_cdr;
   logic                vji_sdr;
   logic                vji_udr;
   logic                vji_rti;

   modport slave (
      input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo,
      output cmd_ready, rsp_valid, rsp_dr, vji_tck, vji_tdi, vji_ir_in,
      output vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
   );

   modport master (
      output cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo,
      input  cmd_ready, rsp_valid, rsp_dr, vji_tck, vji_tdi, vji_ir_in,
      input  vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
   );
endinterface

// File: rtl/nios_dbg_jtag_initiator.sv
// nios_dbg_jtag_initiator: host-side sequencer for the Nios II debug-slave
// virtual-JTAG port. Each accepted command runs UIR -> CDR -> SDR x DR_WIDTH
// -> UDR -> RTI x RTI_CYCLES on a divided tck and returns the captured tdo bits.
// Optional build macro NIOS_DBG_JTAG_IR_CACHE_EN: remember the last issued IR
// and skip the UIR period when the next command carries the same IR.
module nios_dbg_jtag_initiator #(
   parameter int DR_WIDTH   = 38,
   parameter int IR_WIDTH   = 2,
   parameter int TCK_HALF   = 2,
   parameter int RTI_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   nios_dbg_jtag_initiator_if.slave bus
);
   localparam int BIT_W = $clog2(DR_WIDTH + 1);
   localparam int RTI_W = $clog2(RTI_CYCLES + 1);
   localparam int CNT_W = (BIT_W > RTI_W) ? BIT_W : RTI_W;
   localparam int PH_W  = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UIR  = 3'd1,
      CDR  = 3'd2,
      SDR  = 3'd3,
      UDR  = 3'd4,
      RTI  = 3'd5
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [PH_W-1:0]     ph;
   logic                tck;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic [DR_WIDTH-1:0] tx_sr;
   logic [DR_WIDTH-1:0] tx_nxt;
   logic [DR_WIDTH-1:0] rx_sr;
   logic [DR_WIDTH-1:0] rx_nxt;
   logic [DR_WIDTH-1:0] rsp_dr;
   logic [DR_WIDTH-1:0] rsp_dr_nxt;
   logic [IR_WIDTH-1:0] ir;
   logic [IR_WIDTH-1:0] ir_nxt;
   logic                rsp_valid;
   logic                rsp_valid_nxt;
   logic                cmd_ready;
   logic                half_end;
   logic                tck_rise;
   logic                period_end;
   logic                accept;
   logic                done;
   logic                skip_uir;
   logic                uir;
   logic                cdr;
   logic                sdr;
   logic                udr;
   logic                rti;
   logic                tdi;

   assign half_end   = (ph == PH_W'(TCK_HALF - 1));
   assign tck_rise   = half_end & ~tck;
   assign period_end = half_end & tck;

`ifdef NIOS_DBG_JTAG_IR_CACHE_EN
   logic ir_cached;

   // Cache flag: set once any IR has been issued; ir itself is the cached value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_cached <= 1'b0;
      end else if (accept) begin
         ir_cached <= 1'b1;
      end else begin
         ir_cached <= ir_cached;
      end
   end

   assign skip_uir = ir_cached && (bus.cmd_ir == ir);
`else
   assign skip_uir = 1'b0;
`endif

   // tck divider: runs only while a scan is in progress, parked low in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ph  <= {PH_W{1'b0}};
         tck <= 1'b0;
      end else if (state == IDLE || state_nxt == IDLE) begin
         ph  <= {PH_W{1'b0}};
         tck <= 1'b0;
      end else if (half_end) begin
         ph  <= {PH_W{1'b0}};
         tck <= ~tck;
      end else begin
         ph  <= ph + PH_W'(1);
         tck <= tck;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, shift-register and response logic; transitions only at period ends
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      tx_nxt        = tx_sr;
      rx_nxt        = rx_sr;
      ir_nxt        = ir;
      rsp_dr_nxt    = rsp_dr;
      accept        = 1'b0;
      done          = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready) begin
               accept    = 1'b1;
               ir_nxt    = bus.cmd_ir;
               tx_nxt    = bus.cmd_dr;
               rx_nxt    = {DR_WIDTH{1'b0}};
               cnt_nxt   = {CNT_W{1'b0}};
               state_nxt = skip_uir ? CDR : UIR;
            end else begin
               state_nxt = IDLE;
            end
         end
         UIR: begin
            if (period_end) begin
               state_nxt = CDR;
            end else begin
               state_nxt = UIR;
            end
         end
         CDR: begin
            if (period_end) begin
               state_nxt = SDR;
               cnt_nxt   = CNT_W'(DR_WIDTH);
            end else begin
               state_nxt = CDR;
            end
         end
         SDR: begin
            if (tck_rise) begin
               rx_nxt = {bus.vji_tdo, rx_sr[DR_WIDTH-1:1]};
            end else begin
               rx_nxt = rx_sr;
            end
            if (period_end) begin
               tx_nxt  = {1'b0, tx_sr[DR_WIDTH-1:1]};
               cnt_nxt = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state_nxt = UDR;
               end else begin
                  state_nxt = SDR;
               end
            end else begin
               state_nxt = SDR;
            end
         end
         UDR: begin
            if (period_end) begin
               state_nxt = RTI;
               cnt_nxt   = CNT_W'(RTI_CYCLES);
            end else begin
               state_nxt = UDR;
            end
         end
         RTI: begin
            if (period_end) begin
               cnt_nxt = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state_nxt  = IDLE;
                  done       = 1'b1;
                  rsp_dr_nxt = rx_sr;
               end else begin
                  state_nxt = RTI;
               end
            end else begin
               state_nxt = RTI;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (done) begin
         rsp_valid_nxt = 1'b1;
      end else if (rsp_valid && bus.rsp_ready) begin
         rsp_valid_nxt = 1'b0;
      end else begin
         rsp_valid_nxt = rsp_valid;
      end
   end

   // Datapath and registered outputs, all derived from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= {CNT_W{1'b0}};
         tx_sr     <= {DR_WIDTH{1'b0}};
         rx_sr     <= {DR_WIDTH{1'b0}};
         rsp_dr    <= {DR_WIDTH{1'b0}};
         ir        <= {IR_WIDTH{1'b0}};
         rsp_valid <= 1'b0;
         cmd_ready <= 1'b1;
         uir       <= 1'b0;
         cdr       <= 1'b0;
         sdr       <= 1'b0;
         udr       <= 1'b0;
         rti       <= 1'b0;
         tdi       <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         tx_sr     <= tx_nxt;
         rx_sr     <= rx_nxt;
         rsp_dr    <= rsp_dr_nxt;
         ir        <= ir_nxt;
         rsp_valid <= rsp_valid_nxt;
         cmd_ready <= (state_nxt == IDLE) && !rsp_valid_nxt;
         uir       <= (state_nxt == UIR);
         cdr       <= (state_nxt == CDR);
         sdr       <= (state_nxt == SDR);
         udr       <= (state_nxt == UDR);
         rti       <= (state_nxt == RTI);
         tdi       <= (state_nxt == SDR) ? tx_nxt[0] : 1'b0;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_dr    = rsp_dr;
   assign bus.vji_tck   = tck;
   assign bus.vji_tdi   = tdi;
   assign bus.vji_ir_in = ir;
   assign bus.vji_uir   = uir;
   assign bus.vji_cdr   = cdr;
   assign bus.vji_sdr   = sdr;
   assign bus.vji_udr   = udr;
   assign bus.vji_rti   = rti;
endmodule

// File: tb/tb_nios_dbg_jtag_initiator.sv
// Self-checking bench for nios_dbg_jtag_initiator: random and directed scans
// compared against a period-level model of the virtual-JTAG sequence.
module tb_nios_dbg_jtag_initiator;
   localparam int DRW = 38;
   localparam int IRW = 2;
   localparam int TH  = 2;
   localparam int RTC = 2;
   localparam int PER = 2 * TH;
   localparam logic [4:0] S_UIR = 5'b10000;
   localparam logic [4:0] S_CDR = 5'b01000;
   localparam logic [4:0] S_SDR = 5'b00100;
   localparam logic [4:0] S_UDR = 5'b00010;
   localparam logic [4:0] S_RTI = 5'b00001;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   // model state: last issued IR for the optional UIR-skip feature
   logic [IRW-1:0] mdl_ir = '0;
   bit             mdl_ir_valid = 1'b0;

   // observations of the most recent scan
   int             obs_lat;
   int             obs_bad;
   int             obs_wait;
   int             obs_uir;
   bit             obs_skip;
   logic [DRW-1:0] obs_tdi;
   logic [DRW-1:0] obs_rsp;
   string          obs_runs;

   nios_dbg_jtag_initiator_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) bus ();

   nios_dbg_jtag_initiator #(
      .DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(TH), .RTI_CYCLES(RTC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic int exp_lat(input bit skip);
      return ((skip ? 2 : 3) + DRW + RTC) * PER + 1;
   endfunction

   function automatic string exp_runs(input bit skip);
      string s;
      s = "";
      if (!skip) s = {s, $sformatf("%02h:%0d ", S_UIR, PER)};
      s = {s, $sformatf("%02h:%0d ", S_CDR, PER)};
      s = {s, $sformatf("%02h:%0d ", S_SDR, DRW * PER)};
      s = {s, $sformatf("%02h:%0d ", S_UDR, PER)};
      s = {s, $sformatf("%02h:%0d ", S_RTI, RTC * PER)};
      return s;
   endfunction

   function automatic logic [DRW-1:0] rnd_dr();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[DRW-1:0];
   endfunction

   // Issue one command (caller sits at a negedge) and watch it through to rsp_valid.
   // tdo is looped back from tdi, or taken from pat when use_pat is set.
   // abort_cyc / abort_bit (>=0) assert reset at that point and return.
   task automatic do_scan(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                          input bit use_pat, input logic [DRW-1:0] pat,
                          input int abort_cyc, input int abort_bit);
      int         cyc;
      int         sdr_cyc;
      int         bitn;
      logic [4:0] code;
      logic [4:0] last;
      logic [4:0] rc[$];
      int         rl[$];
      obs_lat = -1; obs_bad = 0; obs_wait = 0; obs_uir = 0;
      obs_tdi = '0; obs_rsp = '0; obs_runs = ""; obs_skip = 1'b0;
      bus.cmd_ir = ir; bus.cmd_dr = dr; bus.cmd_valid = 1'b1;
      while (bus.cmd_ready !== 1'b1 && obs_wait < 1000) begin
         @(negedge clk);
         obs_wait++;
      end
      if (obs_wait >= 1000) begin
         bus.cmd_valid = 1'b0;
         return;
      end
`ifdef NIOS_DBG_JTAG_IR_CACHE_EN
      obs_skip = mdl_ir_valid && (ir == mdl_ir);
`else
      obs_skip = 1'b0;
`endif
      mdl_ir = ir; mdl_ir_valid = 1'b1;
      cyc = 0; sdr_cyc = 0; bitn = -1; last = 5'b00000;
      while (cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) bus.cmd_valid = 1'b0;
         code = {bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti};
         if (bus.rsp_valid === 1'b1) begin
            obs_lat = cyc;
            obs_rsp = bus.rsp_dr;
            if (code !== 5'b00000 || bus.vji_tck !== 1'b0 || bus.vji_tdi !== 1'b0) obs_bad++;
            break;
         end
         if ($countones(code) != 1) obs_bad++;
         if (code == S_UIR) obs_uir++;
         if (rc.size() == 0 || code != last) begin
            rc.push_back(code);
            rl.push_back(1);
         end else begin
            rl[rl.size()-1] = rl[rl.size()-1] + 1;
         end
         last = code;
         if (bus.vji_tck !== (((cyc - 1) % PER) >= TH)) obs_bad++;
         if (bus.vji_ir_in !== ir) obs_bad++;
         if (code == S_SDR) begin
            bitn = sdr_cyc / PER;
            if (bitn < DRW) begin
               if (bus.vji_tck === 1'b1) obs_tdi[bitn] = bus.vji_tdi;
               bus.vji_tdo = use_pat ? pat[bitn] : bus.vji_tdi;
            end
            sdr_cyc++;
         end else begin
            if (bus.vji_tdi !== 1'b0) obs_bad++;
            bus.vji_tdo = 1'b0;
         end
         if ((abort_cyc >= 0 && cyc == abort_cyc) ||
             (abort_bit >= 0 && code == S_SDR && bitn == abort_bit && bus.vji_tck === 1'b1)) begin
            reset = 1'b1;
            bus.vji_tdo = 1'b0;
            mdl_ir_valid = 1'b0;
            return;
         end
      end
      for (int i = 0; i < rc.size(); i++) obs_runs = {obs_runs, $sformatf("%02h:%0d ", rc[i], rl[i])};
   endtask

   task automatic consume();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      int seen;
      @(negedge clk);
      n_tests++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.vji_tck !== 1'b0 ||
          bus.vji_uir !== 1'b0 || bus.vji_sdr !== 1'b0 || bus.vji_ir_in !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: cmd_ready=%b rsp_valid=%b tck=%b uir=%b sdr=%b ir=%b want 1,0,0,0,0,0",
                  bus.cmd_ready, bus.rsp_valid, bus.vji_tck, bus.vji_uir, bus.vji_sdr, bus.vji_ir_in);
      end
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
      end
      do_scan(2'b01, rnd_dr(), 1'b0, '0, 30, -1);
      #1;
      n_tests++;
      if ({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti, bus.vji_tck, bus.vji_tdi} !== 7'b0 ||
          bus.vji_ir_in !== '0 || bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_midrun_clear: strobes/tck/tdi=%b ir=%b rsp_valid=%b want all 0",
                  {bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti, bus.vji_tck, bus.vji_tdi},
                  bus.vji_ir_in, bus.rsp_valid);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_midrun_ready: cmd_ready=%b rsp_valid=%b want 1,0", bus.cmd_ready, bus.rsp_valid);
      end
      seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++; $display("FAIL reset_midrun_no_rsp: rsp_valid cycles=%0d want 0", seen);
      end
   endtask

   task automatic test_single_scan();
      logic [DRW-1:0] d;
      d = 38'h2A_5555_AAAA;
      do_scan(2'b01, d, 1'b0, '0, -1, -1);
      n_tests++;
      if (obs_lat != exp_lat(obs_skip)) begin
         n_fail++; $display("FAIL single_latency: got %0d want %0d", obs_lat, exp_lat(obs_skip));
      end
      n_tests++;
      if (obs_runs != exp_runs(obs_skip)) begin
         n_fail++; $display("FAIL single_strobe_order: got '%s' want '%s'", obs_runs, exp_runs(obs_skip));
      end
      n_tests++;
      if (obs_tdi !== d) begin
         n_fail++; $display("FAIL single_tdi: got %h want %h", obs_tdi, d);
      end
      n_tests++;
      if (obs_rsp !== d) begin
         n_fail++; $display("FAIL single_rsp: got %h want %h", obs_rsp, d);
      end
      n_tests++;
      if (obs_bad != 0) begin
         n_fail++; $display("FAIL single_protocol: got %0d violations want 0", obs_bad);
      end
      consume();
      n_tests++;
      if (bus.vji_ir_in !== 2'b01) begin
         n_fail++; $display("FAIL single_ir_hold: got %b want 01", bus.vji_ir_in);
      end
   endtask

   task automatic test_tdo_capture();
      do_scan(2'b10, rnd_dr(), 1'b1, 38'h0_0000_000F, -1, -1);
      n_tests++;
      if (obs_rsp !== 38'h0_0000_000F || obs_lat != exp_lat(obs_skip)) begin
         n_fail++; $display("FAIL tdo_capture: rsp=%h lat=%0d want %h lat=%0d", obs_rsp, obs_lat, 38'h0_0000_000F, exp_lat(obs_skip));
      end
      consume();
   endtask

   task automatic test_backpressure();
      logic [DRW-1:0] d1;
      logic [DRW-1:0] d2;
      int             bad;
      d1 = rnd_dr(); d2 = rnd_dr();
      do_scan(2'b01, d1, 1'b0, '0, -1, -1);
      n_tests++;
      if (obs_rsp !== d1) begin
         n_fail++; $display("FAIL bp_first_rsp: got %h want %h", obs_rsp, d1);
      end
      bus.cmd_ir = 2'b10; bus.cmd_dr = d2; bus.cmd_valid = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_dr !== d1) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
      end
      bus.rsp_ready = 1'b1;
      n_tests++;
      if (bus.cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_same_cycle_ready: got %b want 0", bus.cmd_ready);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      n_tests++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_next_cycle_ready: cmd_ready=%b rsp_valid=%b want 1,0", bus.cmd_ready, bus.rsp_valid);
      end
      do_scan(2'b10, d2, 1'b0, '0, -1, -1);
      n_tests++;
      if (obs_wait != 0 || obs_rsp !== d2 || obs_lat != exp_lat(obs_skip)) begin
         n_fail++; $display("FAIL bp_second_scan: wait=%0d rsp=%h lat=%0d want 0 %h %0d", obs_wait, obs_rsp, obs_lat, d2, exp_lat(obs_skip));
      end
      consume();
   endtask

   task automatic test_reset_mid_sdr();
      logic [DRW-1:0] d;
      int             seen;
      do_scan(2'b11, rnd_dr(), 1'b0, '0, -1, 17);
      @(negedge clk);
      n_tests++;
      if ({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti, bus.vji_tck, bus.vji_tdi} !== 7'b0 ||
          bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL sdr_reset_clear: strobes/tck/tdi=%b rsp_valid=%b cmd_ready=%b want 0,0,1",
                  {bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti, bus.vji_tck, bus.vji_tdi},
                  bus.rsp_valid, bus.cmd_ready);
      end
      reset = 1'b0;
      seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++; $display("FAIL sdr_reset_no_rsp: rsp_valid cycles=%0d want 0", seen);
      end
      d = rnd_dr();
      do_scan(2'b01, d, 1'b0, '0, -1, -1);
      n_tests++;
      if (obs_rsp !== d || obs_lat != exp_lat(obs_skip) || obs_runs != exp_runs(obs_skip) || obs_bad != 0) begin
         n_fail++; $display("FAIL sdr_reset_recover: rsp=%h lat=%0d bad=%0d want %h %0d 0", obs_rsp, obs_lat, obs_bad, d, exp_lat(obs_skip));
      end
      consume();
   endtask

   task automatic test_ir_cache();
      int lat2;
      int uir2;
`ifdef NIOS_DBG_JTAG_IR_CACHE_EN
      lat2 = 169; uir2 = 0;
`else
      lat2 = 173; uir2 = PER;
`endif
      do_scan(2'b10, rnd_dr(), 1'b0, '0, -1, -1);
      n_tests++;
      if (obs_lat != exp_lat(obs_skip)) begin
         n_fail++; $display("FAIL cache_first_lat: got %0d want %0d", obs_lat, exp_lat(obs_skip));
      end
      consume();
      do_scan(2'b10, rnd_dr(), 1'b0, '0, -1, -1);
      n_tests++;
      if (obs_lat != lat2 || obs_uir != uir2) begin
         n_fail++; $display("FAIL cache_same_ir: lat=%0d uir_cycles=%0d want %0d %0d", obs_lat, obs_uir, lat2, uir2);
      end
      consume();
      do_scan(2'b11, rnd_dr(), 1'b0, '0, -1, -1);
      n_tests++;
      if (obs_lat != 173 || obs_uir != PER) begin
         n_fail++; $display("FAIL cache_new_ir: lat=%0d uir_cycles=%0d want 173 %0d", obs_lat, obs_uir, PER);
      end
      consume();
   endtask

   task automatic test_random();
      logic [IRW-1:0] ir;
      logic [DRW-1:0] d;
      logic [DRW-1:0] p;
      for (int i = 0; i < 6; i++) begin
         ir = IRW'($urandom_range(0, 3));
         d = rnd_dr(); p = rnd_dr();
         do_scan(ir, d, 1'b1, p, -1, -1);
         n_tests++;
         if (obs_lat != exp_lat(obs_skip) || obs_runs != exp_runs(obs_skip)) begin
            n_fail++; $display("FAIL rand%0d_timing: lat=%0d runs='%s' want %0d '%s'", i, obs_lat, obs_runs, exp_lat(obs_skip), exp_runs(obs_skip));
         end
         n_tests++;
         if (obs_tdi !== d || obs_rsp !== p || obs_bad != 0) begin
            n_fail++; $display("FAIL rand%0d_data: tdi=%h rsp=%h bad=%0d want %h %h 0", i, obs_tdi, obs_rsp, obs_bad, d, p);
         end
         consume();
      end
   endtask

   initial begin
      reset = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_dr = '0;
      bus.rsp_ready = 1'b0; bus.vji_tdo = 1'b0;
      #2 reset = 1'b1;
      mdl_ir_valid = 1'b0;
      test_reset();
      test_single_scan();
      test_tdo_capture();
      test_backpressure();
      test_reset_mid_sdr();
      test_ir_cache();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/nios_dbg_jtag_initiator.md
Name: nios_dbg_jtag_initiator

Overview:
- On-chip initiator for the Nios II debug-slave virtual-JTAG interface. It sits on the host side of the link and drives what sld_virtual_jtag_basic would drive: tck, tdi, ir_in, rti, cdr, sdr, udr and uir.
- Receives an IR/DR command on a valid/ready port and generates the full UIR→CDR→SDR→UDR→RTI sequence on a divided tck.
- Captures tdo into a response word. Used for in-system self-test and simulation of the debug path without a physical JTAG cable.

Parameters:
- DR_WIDTH, 38, shift-register length per scan; matches jdo/sr width.
- IR_WIDTH, 2, virtual IR width.
- TCK_HALF, 2, clk cycles per tck half-period; legal range ≥1.
- RTI_CYCLES, 2, tck periods spent in run-test-idle after UDR; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_ir  in  IR_WIDTH  IR value for this scan.
- cmd_dr  in  DR_WIDTH  data shifted out on tdi, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_dr  out  DR_WIDTH  captured tdo bits; bit0 = first bit shifted.
- vji_tck  out  1  generated tck.
- vji_tdi  out  1  serial data to the target.
- vji_tdo  in  1  serial data from the target.
- vji_ir_in  out  IR_WIDTH  IR presented to the target.
- vji_uir / vji_cdr / vji_sdr / vji_udr / vji_rti  out  1 each  virtual-state strobes.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, except cmd_ready=1 when no response is pending; shift registers cleared.
- Timing unit: one tck period = 2*TCK_HALF clk cycles. tck is 0 for the first TCK_HALF cycles and 1 for the second. All vji_* strobes, vji_tdi and vji_ir_in change only at period start, i.e. on the clk edge where tck falls or stays low.
- States and sequence:
  - IDLE: cmd_ready = !rsp_valid. On accept, latch cmd_ir into vji_ir_in and cmd_dr into tx_sr, clear rx_sr, go to UIR.
  - UIR: vji_uir=1 for 1 period.
  - CDR: vji_cdr=1 for 1 period.
  - SDR: vji_sdr=1 for DR_WIDTH periods. vji_tdi=tx_sr[0] per period; tx_sr shifts right at each period end. vji_tdo is sampled on the clk edge where tck goes 0→1, with rx_sr <= {tdo, rx_sr[DR_WIDTH-1:1]}.
  - UDR: vji_udr=1 for 1 period.
  - RTI: vji_rti=1 for RTI_CYCLES periods, then rsp_dr<=rx_sr, rsp_valid<=1, go to IDLE.
- Exactly one strobe is high outside IDLE. vji_tdi=0 outside SDR. vji_ir_in holds its value until the next accept.
- Latency, accept to rsp_valid: (3+DR_WIDTH+RTI_CYCLES)*2*TCK_HALF + 1 clk. Defaults give 173.
- rsp_valid holds with rsp_dr stable until rsp_ready. A new command is not accepted while rsp_valid=1. Simultaneous rsp_ready and cmd_valid in IDLE: the response is consumed that cycle and the command is accepted next cycle.
- cmd_valid while busy: ignored, cmd_ready=0.
- Reset mid-scan: immediate return to the reset state. Partial rx data is discarded; no response is issued.
- Counters: bit counter sized clog2(DR_WIDTH+1) and phase counter clog2(TCK_HALF). Neither may wrap within a phase.

Optional Feature:
- Macro NIOS_DBG_JTAG_IR_CACHE_EN.
- Defined: the block keeps the last issued IR plus a valid flag, which is cleared by reset. If cmd_ir equals the cached IR and the flag is set, UIR is skipped (accept→CDR). Latency drops by 2*TCK_HALF clk.
- Undefined: UIR is always issued.

Test Plan:
1. Reset defaults: reset=1 mid-run → all vji_* =0, rsp_valid=0, cmd_ready=1 next cycle after release.
2. Single scan with defaults: cmd_ir=2'b01, cmd_dr=38'h2A_5555_AAAA, tdo looped to tdi → tdi sequence LSB-first matches cmd_dr, rsp_dr=38'h2A_5555_AAAA, rsp_valid exactly 173 clk after accept, strobe order UIR,CDR,SDR×38,UDR,RTI×2.
3. tdo capture: tdo tied 1 for first 4 SDR periods then 0 → rsp_dr=38'h0_0000_000F.
4. Backpressure: rsp_ready=0 for 50 cycles with cmd_valid=1 → cmd_ready=0 throughout, rsp_dr stable; rsp_ready=1 → accept on the following cycle.
5. Reset mid-SDR at bit 17 → outputs cleared within one clk, no rsp_valid; the next command completes normally.
6. With NIOS_DBG_JTAG_IR_CACHE_EN defined: two scans both with IR=2'b10 → second has no vji_uir pulse, latency 169; then IR=2'b11 → UIR present, latency 173.
